// File: rtl/matrix_mem_responder_pkg.sv
// Shared sizing defaults and state encoding for the matrix memory responder.
package matrix_mem_responder_pkg;
  localparam int DEF_ELEMENT_WIDTH = 16;
  localparam int BRAM_ADDR_WIDTH   = 6;
  localparam int MEM_DEPTH         = 1 << BRAM_ADDR_WIDTH;

  // S_CLEAR sweeps zeros through the array; S_RUN serves op and host traffic.
  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/matrix_mem_responder_array.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Addresses wrap modulo DEPTH; no bounds checking.
module matrix_mem_array #(
  parameter int ELEMENT_WIDTH = 16,
  parameter int ADDR_WIDTH    = 6,
  parameter int DEPTH         = 1 << ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_WIDTH-1:0]    waddr,
  input  logic [ELEMENT_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]    raddr,
  output logic [ELEMENT_WIDTH-1:0] rdata
);
  logic [ELEMENT_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0]    widx;
  logic [ADDR_WIDTH-1:0]    ridx;

  assign widx  = ADDR_WIDTH'(32'(waddr) % DEPTH);
  assign ridx  = ADDR_WIDTH'(32'(raddr) % DEPTH);
  assign rdata = mem[ridx];

  // Single write port; the caller has already resolved clear/op/host priority.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end
endmodule

// File: rtl/matrix_mem_responder.sv
// Matrix storage responder: op port (priority, 1-edge registered reads),
// lower-priority host port with combinational grant, and a zero-fill sweep
// after reset or on clr_start.
module matrix_mem_responder
  import matrix_mem_responder_pkg::*;
#(
  parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
  parameter int ADDR_WIDTH    = BRAM_ADDR_WIDTH,
  parameter int DEPTH         = 1 << ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_rd_en,
  input  logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  input  logic                     mem_wr_en,
  input  logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_wr_data,
  input  logic                     host_req,
  input  logic                     host_we,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  input  logic [ELEMENT_WIDTH-1:0] host_wdata,
  output logic                     host_ack,
  output logic [ELEMENT_WIDTH-1:0] host_rdata,
  output logic                     host_rvalid,
  input  logic                     clr_start,
  output logic                     busy
);
  state_t                   state;
  logic [ADDR_WIDTH-1:0]    clr_addr;
  logic                     run;
  logic                     arr_we;
  logic [ADDR_WIDTH-1:0]    arr_waddr;
  logic [ELEMENT_WIDTH-1:0] arr_wdata;
  logic [ADDR_WIDTH-1:0]    arr_raddr;
  logic [ELEMENT_WIDTH-1:0] arr_rdata;

  assign run      = (state == S_RUN);
  assign host_ack = host_req & run & ~mem_rd_en & ~mem_wr_en & ~clr_start;

  // Op read wins the shared read port; host only reads when the op port is idle.
  assign arr_raddr = mem_rd_en ? mem_rd_addr : host_addr;

  // Write mux: clear sweep > op write > granted host write; nothing lands during reset.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = mem_wr_addr;
    arr_wdata = mem_wr_data;
    if (!run) begin
      arr_we    = 1'b1;
      arr_waddr = clr_addr;
      arr_wdata = '0;
    end else if (mem_wr_en) begin
      arr_we    = 1'b1;
    end else if (host_ack && host_we) begin
      arr_we    = 1'b1;
      arr_waddr = host_addr;
      arr_wdata = host_wdata;
    end
    arr_we = arr_we & rst_n;
  end

  matrix_mem_array #(
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DEPTH         (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  // Clear/run FSM with registered busy; clr_start is only honoured in S_RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          if (clr_start) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end

  // Independent op and host read registers; reading before the write lands
  // gives read-before-write on same-address collisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_rd_data <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      if (run && mem_rd_en) mem_rd_data <= arr_rdata;
      if (host_ack && !host_we) begin
        host_rdata  <= arr_rdata;
        host_rvalid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Randomized + directed bench with a behavioural model of the memory responder.
module tb_matrix_mem_responder;
  localparam int EW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_rd_en = 1'b0;
  logic [AW-1:0] mem_rd_addr = '0;
  logic [EW-1:0] mem_rd_data;
  logic          mem_wr_en = 1'b0;
  logic [AW-1:0] mem_wr_addr = '0;
  logic [EW-1:0] mem_wr_data = '0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [EW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [EW-1:0] host_rdata;
  logic          host_rvalid;
  logic          clr_start = 1'b0;
  logic          busy;

  int n_chk = 0;
  int n_pass = 0;

  matrix_mem_responder #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .clr_start(clr_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Behavioural model: array contents, remaining clear words, expected outputs.
  logic [EW-1:0] mdl [DEPTH];
  int            clear_left = DEPTH;
  logic [EW-1:0] e_rd = '0;
  logic [EW-1:0] e_hr = '0;
  logic          e_hv = 1'b0;
  bit            live = 1'b0;

  initial for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

  function automatic bit model_ack();
    return host_req && clear_left == 0 && !mem_rd_en && !mem_wr_en && !clr_start;
  endfunction

  always @(posedge clk) begin
    bit a;
    if (!rst_n) begin
      e_rd = '0; e_hr = '0; e_hv = 1'b0; clear_left = DEPTH; live = 1'b1;
    end else if (clear_left > 0) begin
      mdl[DEPTH - clear_left] = '0;
      clear_left--;
      e_hv = 1'b0;
    end else begin
      a = model_ack();
      e_hv = 1'b0;
      if (mem_rd_en) e_rd = mdl[mem_rd_addr];
      if (a && !host_we) begin e_hr = mdl[host_addr]; e_hv = 1'b1; end
      if (mem_wr_en) mdl[mem_wr_addr] = mem_wr_data;
      else if (a && host_we) mdl[host_addr] = host_wdata;
      if (clr_start) clear_left = DEPTH;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      chk("busy", 32'(busy), 32'(clear_left > 0));
      chk("host_ack", 32'(host_ack), 32'(model_ack()));
      chk("mem_rd_data", 32'(mem_rd_data), 32'(e_rd));
      chk("host_rdata", 32'(host_rdata), 32'(e_hr));
      chk("host_rvalid", 32'(host_rvalid), 32'(e_hv));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin step(); n++; end
  endtask

  task automatic op_wr(input logic [AW-1:0] a, input logic [EW-1:0] d);
    mem_wr_en = 1'b1; mem_wr_addr = a; mem_wr_data = d;
    step();
    mem_wr_en = 1'b0;
  endtask

  task automatic op_rd(input logic [AW-1:0] a);
    mem_rd_en = 1'b1; mem_rd_addr = a;
    step();
    mem_rd_en = 1'b0;
  endtask

  initial begin
    int  n;
    bit  a;

    // Reset and initial sweep.
    step(); step();
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rd", 32'(mem_rd_data), 32'h0);
    chk("reset_rvalid", 32'(host_rvalid), 32'd0);
    rst_n = 1'b1;
    wait_clear(n);
    chk("init_clear_cycles", 32'(n), 32'd64);
    op_rd(6'd0);  chk("rd0_zero", 32'(mem_rd_data), 32'h0);
    op_rd(6'd31); chk("rd31_zero", 32'(mem_rd_data), 32'h0);
    op_rd(6'd63); chk("rd63_zero", 32'(mem_rd_data), 32'h0);

    // Write then read later; hold through idle cycles and a host read.
    op_wr(6'd5, 16'h1234);
    step();
    op_rd(6'd5);
    chk("rd5", 32'(mem_rd_data), 32'h1234);
    repeat (5) step();
    chk("rd5_hold_idle", 32'(mem_rd_data), 32'h1234);
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd7;
    step();
    host_req = 1'b0;
    chk("host_rd7_rvalid", 32'(host_rvalid), 32'd1);
    chk("host_rd7_data", 32'(host_rdata), 32'h0);
    chk("rd5_hold_host", 32'(mem_rd_data), 32'h1234);

    // Same-cycle read and write: old data, then new data.
    mem_wr_en = 1'b1; mem_wr_addr = 6'd9; mem_wr_data = 16'hBEEF;
    mem_rd_en = 1'b1; mem_rd_addr = 6'd9;
    step();
    mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    chk("rbw_old", 32'(mem_rd_data), 32'h0);
    op_rd(6'd9);
    chk("rbw_new", 32'(mem_rd_data), 32'hBEEF);

    // Host read stalled by three op reads.
    host_req = 1'b1; host_we = 1'b0; host_addr = 6'd5;
    for (int i = 0; i < 3; i++) begin
      mem_rd_en = 1'b1; mem_rd_addr = AW'(i);
      #2 chk("host_stall_ack", 32'(host_ack), 32'd0);
      step();
    end
    mem_rd_en = 1'b0;
    #2 chk("host_grant_ack", 32'(host_ack), 32'd1);
    step();
    host_req = 1'b0;
    chk("host_rd5_rvalid", 32'(host_rvalid), 32'd1);
    chk("host_rd5_data", 32'(host_rdata), 32'h1234);
    step();
    chk("host_rvalid_pulse", 32'(host_rvalid), 32'd0);

    // Fill, clear with dropped writes during the sweep.
    for (int i = 0; i < DEPTH; i++) op_wr(AW'(i), 16'hAAAA);
    clr_start = 1'b1; step(); clr_start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      mem_wr_en = 1'($urandom); mem_wr_addr = AW'($urandom); mem_wr_data = 16'h5555;
      step(); n++;
    end
    mem_wr_en = 1'b0;
    chk("clr_cycles", 32'(n), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      op_rd(AW'(i));
      chk("clr_zero", 32'(mem_rd_data), 32'h0);
    end

    // Reset in the middle of a sweep.
    op_wr(6'd3, 16'h7777);
    op_rd(6'd3);
    clr_start = 1'b1; step(); clr_start = 1'b0;
    repeat (20) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_rd", 32'(mem_rd_data), 32'h0);
    wait_clear(n);
    chk("midrst_clear_cycles", 32'(n), 32'd64);

    // Randomized traffic; host keeps its request stable until acknowledged.
    for (int c = 0; c < 3000; c++) begin
      if (!host_req && $urandom_range(0, 2) == 0) begin
        host_req = 1'b1; host_we = 1'($urandom);
        host_addr = AW'($urandom); host_wdata = EW'($urandom);
      end
      mem_rd_en = ($urandom_range(0, 2) == 0);
      mem_rd_addr = AW'($urandom);
      mem_wr_en = ($urandom_range(0, 3) == 0);
      mem_wr_addr = AW'($urandom); mem_wr_data = EW'($urandom);
      clr_start = ($urandom_range(0, 399) == 0);
      #2 a = host_ack;
      step();
      if (a) host_req = 1'b0;
    end
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; clr_start = 1'b0; host_req = 1'b0;
    repeat (70) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/matrix_mem_responder.md
# matrix_mem_responder

Single-clock matrix storage block that answers the BRAM-style read/write requests issued by the matrix operation engines (add, scalar, transpose, multiply). It also serves a lower-priority host port used by the UI/loader path, and it zero-fills the whole array after reset or on command. It sits between the op engines' shared memory bus and the storage array, so every op engine sees one fixed, registered read latency.

## Interface
- ELEMENT_WIDTH, default `ELEMENT_WIDTH: data word width.
- ADDR_WIDTH, default `BRAM_ADDR_WIDTH: word address width.
- DEPTH, default 1<<ADDR_WIDTH: number of words, swept by clear.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- mem_rd_en  in  1  op-port read request, one-cycle pulse.
- mem_rd_addr  in  ADDR_WIDTH  op-port read address.
- mem_rd_data  out  ELEMENT_WIDTH  op-port read data, registered, held until the next accepted op read.
- mem_wr_en  in  1  op-port write strobe.
- mem_wr_addr  in  ADDR_WIDTH  op-port write address.
- mem_wr_data  in  ELEMENT_WIDTH  op-port write data.
- host_req  in  1  host request; held high until acknowledged.
- host_we  in  1  host request type: 1 = write, 0 = read.
- host_addr  in  ADDR_WIDTH  host address.
- host_wdata  in  ELEMENT_WIDTH  host write data.
- host_ack  out  1  combinational grant; the host transaction executes at the edge ending this cycle.
- host_rdata  out  ELEMENT_WIDTH  host read data, registered, held until the next host read.
- host_rvalid  out  1  one-cycle pulse after a granted host read.
- clr_start  in  1  pulse that requests a full zero-fill.
- busy  out  1  high while clearing.

## Operation
- States:
  - S_CLEAR: sweep clr_addr from 0 to DEPTH-1, writing 0 to one word per cycle. After writing DEPTH-1, go to S_RUN.
  - S_RUN: service requests. clr_start=1 moves to S_CLEAR with clr_addr=0.
- Reset (rst_n=0 at an edge):
  - state = S_CLEAR, clr_addr = 0.
  - Output reset values: mem_rd_data = 0, host_rdata = 0, host_rvalid = 0, busy = 1.
  - Reset mid-operation aborts any sweep or transaction. Array contents are zeroed only by the sweep that follows.
- In S_CLEAR:
  - All op and host requests are ignored; op writes are dropped.
  - mem_rd_data and host_rdata hold; host_ack = 0.
  - clr_start is ignored; the sweep does not restart.
- Op port, which always has priority in S_RUN:
  - Write: array[mem_wr_addr] <= mem_wr_data at the sampling edge.
  - Read: mem_rd_data <= array[mem_rd_addr] at the sampling edge.
  - A read and a write in the same cycle to the same address return the OLD data (read-before-write). A read in any later cycle returns the new data.
- Host port:
  - host_ack = host_req & state==S_RUN & !mem_rd_en & !mem_wr_en & !clr_start.
  - On grant: a write updates the array; a read loads host_rdata and pulses host_rvalid the next cycle.
  - A request that is not granted waits with no loss. The host must keep host_we, host_addr and host_wdata stable while waiting.
- Arithmetic: addresses are used modulo DEPTH (no bounds check). Data passes through unmodified.

## Timing
- Op read latency is 1 edge: request sampled at edge E, data visible after edge E.
  - Op engines sample at least 2 edges after the request, so they capture safely.
- Host read: granted at edge E, so host_rdata is valid and host_rvalid=1 during cycle E..E+1.
- Clear takes exactly DEPTH cycles.
  - busy falls after the edge that writes DEPTH-1.
  - The first op request is accepted at the edge following that.
- Back-to-back op reads, one per cycle, are supported at full rate.

## Structure
- Add to matrix_pkg.vh: MEM_DEPTH, derived as 1<<`BRAM_ADDR_WIDTH. The existing ELEMENT_WIDTH and BRAM_ADDR_WIDTH stay there.
- State encodings are local to this module.
- One sub-module, matrix_mem_array: storage with one synchronous write port and one asynchronous read port.
  - This top owns the write mux (clear > op > host), the read mux, and both output registers.
  - This split lets the op and host read registers hold independently.

## Test plan
Bench parameters: ELEMENT_WIDTH=16, ADDR_WIDTH=6.

- Reset, then run 64 cycles -> busy=1 for exactly 64 cycles. Reads of addresses 0, 31 and 63 all return 0x0000.
- Op write 0x1234 to 5, then op read 5 two cycles later -> mem_rd_data=0x1234 after the read edge. The value holds through 5 idle cycles and through a host read of address 7.
- Op write 0xBEEF and op read at address 9 in the same cycle -> read returns the old value 0x0000. A read one cycle later returns 0xBEEF.
- host_req held for a read of address 5 while the op port issues reads for 3 consecutive cycles -> host_ack=0 for those 3 cycles, then 1. host_rvalid pulses once with host_rdata=0x1234.
- clr_start after filling addresses 0-63 with 0xAAAA, with op writes issued during the sweep -> busy=1 for 64 cycles, the dropped writes leave no effect, and all addresses read 0.
- rst_n low for one cycle in the middle of a sweep (clr_addr=20) -> the sweep restarts at 0, busy stays 1 for 64 more cycles, and mem_rd_data=0.
